// File: rtl/pulse_sequencer.sv
// Real-time pulse-train generator: pulse 1, then cp refocusing pulses (Hahn/CPMG),
// with a receiver-blanking gate and a per-period scope sync. All outputs registered.
module pulse_sequencer #(
  parameter int CNT_W   = 32,
  parameter int MIN_PER = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] per,
  input  logic [CNT_W-1:0] p1wid,
  input  logic [CNT_W-1:0] del,
  input  logic [CNT_W-1:0] p2wid,
  input  logic             pu,
  input  logic [7:0]       cp,
  input  logic             bl_en,
  input  logic [15:0]      p_bl_off,
  output logic             pulse,
  output logic             blank,
  output logic             sync,
  output logic             trunc,
  output logic [7:0]       echo_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_GAP1, S_P2, S_GAPN, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d, w1_sh_q, w1_sh_d, d_sh_q, d_sh_d, w2_sh_q, w2_sh_d;
  logic             pu_sh_q, pu_sh_d, bl_sh_q, bl_sh_d;
  logic [7:0]       cp_sh_q, cp_sh_d;
  logic [15:0]      off_sh_q, off_sh_d, hold_q, hold_d;
  logic             pulse_q, pulse_d, blank_q, blank_d, sync_q, sync_d;
  logic             trunc_q, trunc_d, busy_q, busy_d;
  logic [7:0]       echo_q, echo_d;

  logic             start;
  logic [CNT_W-1:0] per_eff, e_w1, e_d, e_w2;
  logic             e_pu, e_bl;
  logic [7:0]       e_cp;
  logic [15:0]      e_off;
  logic             go_p1, go_gap1, go_p2, go_after;
  logic [8:0]       jn;

  assign per_eff = (per < CNT_W'(MIN_PER)) ? CNT_W'(MIN_PER) : per;
  assign start   = (state_q == S_IDLE) || (cnt_q == per_sh_q - CNT_W'(1));

  // At k=0 the fresh inputs steer the schedule while they are being shadowed.
  assign e_w1  = start ? p1wid    : w1_sh_q;
  assign e_d   = start ? del      : d_sh_q;
  assign e_w2  = start ? p2wid    : w2_sh_q;
  assign e_pu  = start ? pu       : pu_sh_q;
  assign e_bl  = start ? bl_en    : bl_sh_q;
  assign e_cp  = start ? cp       : cp_sh_q;
  assign e_off = start ? p_bl_off : off_sh_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    per_sh_d = per_sh_q;
    w1_sh_d  = w1_sh_q;
    d_sh_d   = d_sh_q;
    w2_sh_d  = w2_sh_q;
    pu_sh_d  = pu_sh_q;
    bl_sh_d  = bl_sh_q;
    cp_sh_d  = cp_sh_q;
    off_sh_d = off_sh_q;
    echo_d   = echo_q;
    sync_d   = 1'b0;
    trunc_d  = 1'b0;
    go_p1    = 1'b0;
    go_gap1  = 1'b0;
    go_p2    = 1'b0;
    go_after = 1'b0;
    jn       = 9'd0;

    if (start) begin
      per_sh_d = per_eff;
      w1_sh_d  = p1wid;
      d_sh_d   = del;
      w2_sh_d  = p2wid;
      pu_sh_d  = pu;
      bl_sh_d  = bl_en;
      cp_sh_d  = cp;
      off_sh_d = p_bl_off;
      cnt_d    = '0;
      sync_d   = 1'b1;
      trunc_d  = (state_q != S_IDLE) && (state_q != S_HOLD);
      echo_d   = 8'd0;
      go_p1    = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q inside {S_P1, S_GAP1, S_P2, S_GAPN}) begin
        if (rem_q > (CNT_W+1)'(1)) begin
          rem_d = rem_q - (CNT_W+1)'(1);
        end else begin
          case (state_q)
            S_P1:    go_gap1 = 1'b1;
            S_GAP1:  go_p2 = 1'b1;
            S_P2: begin
              go_after = 1'b1;
              jn       = {1'b0, echo_q} - 9'd1;
            end
            default: begin
              go_p2 = 1'b1;
              jn    = {1'b0, echo_q};
            end
          endcase
        end
      end
    end

    // Phase entry chain: zero-length phases fall through within the same cycle.
    if (go_p1) begin
      if (e_w1 != '0) begin
        state_d = S_P1;
        rem_d   = {1'b0, e_w1};
      end else begin
        go_gap1 = 1'b1;
      end
    end
    if (go_gap1) begin
      if (e_cp == 8'd0) begin
        state_d = S_HOLD;
      end else if (e_d != '0) begin
        state_d = S_GAP1;
        rem_d   = {1'b0, e_d};
      end else begin
        go_p2 = 1'b1;
        jn    = 9'd0;
      end
    end
    if (go_p2) begin
      echo_d = 8'(jn + 9'd1);
      if (e_w2 != '0) begin
        state_d = S_P2;
        rem_d   = {1'b0, e_w2};
      end else begin
        go_after = 1'b1;
      end
    end
    if (go_after) begin
      if ((jn + 9'd1) >= {1'b0, e_cp}) begin
        state_d = S_HOLD;
      end else if (e_d != '0) begin
        state_d = S_GAPN;
        rem_d   = {e_d, 1'b0};
      end else if (e_w2 == '0) begin
        state_d = S_HOLD;
        echo_d  = e_cp;
      end else begin
        state_d = S_P2;
        rem_d   = {1'b0, e_w2};
        echo_d  = 8'(jn + 9'd2);
      end
    end

    pulse_d = (state_d == S_P1) ? e_pu : (state_d == S_P2);
    busy_d  = state_d inside {S_P1, S_GAP1, S_P2, S_GAPN};

    hold_d = hold_q;
    if (pulse_q && !pulse_d && !start) begin
      hold_d = e_off;
    end else if (start) begin
      hold_d = 16'd0;
    end else if (hold_q != 16'd0) begin
      hold_d = hold_q - 16'd1;
    end
    blank_d = e_bl && (pulse_d || (hold_d != 16'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      per_sh_q <= '0;
      w1_sh_q  <= '0;
      d_sh_q   <= '0;
      w2_sh_q  <= '0;
      pu_sh_q  <= 1'b0;
      bl_sh_q  <= 1'b0;
      cp_sh_q  <= 8'd0;
      off_sh_q <= 16'd0;
      hold_q   <= 16'd0;
      pulse_q  <= 1'b0;
      blank_q  <= 1'b0;
      sync_q   <= 1'b0;
      trunc_q  <= 1'b0;
      busy_q   <= 1'b0;
      echo_q   <= 8'd0;
    end else if (!run) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      hold_q  <= 16'd0;
      pulse_q <= 1'b0;
      blank_q <= 1'b0;
      sync_q  <= 1'b0;
      trunc_q <= 1'b0;
      busy_q  <= 1'b0;
      echo_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      per_sh_q <= per_sh_d;
      w1_sh_q  <= w1_sh_d;
      d_sh_q   <= d_sh_d;
      w2_sh_q  <= w2_sh_d;
      pu_sh_q  <= pu_sh_d;
      bl_sh_q  <= bl_sh_d;
      cp_sh_q  <= cp_sh_d;
      off_sh_q <= off_sh_d;
      hold_q   <= hold_d;
      pulse_q  <= pulse_d;
      blank_q  <= blank_d;
      sync_q   <= sync_d;
      trunc_q  <= trunc_d;
      busy_q   <= busy_d;
      echo_q   <= echo_d;
    end
  end

  assign pulse    = pulse_q;
  assign blank    = blank_q;
  assign sync     = sync_q;
  assign trunc    = trunc_q;
  assign echo_cnt = echo_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: traces are captured per cycle index k and
// compared against hand-derived schedules.
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, pu, bl_en;
  logic [31:0] per, p1wid, del, p2wid;
  logic [7:0]  cp;
  logic [15:0] p_bl_off;
  logic        pulse, blank, sync, trunc, busy;
  logic [7:0]  echo_cnt;

  int checks = 0;
  int errors = 0;

  logic       pul[200], blk[200], bsy[200], syn[200], trc[200];
  logic [7:0] ech[200];

  pulse_sequencer #(.CNT_W(32), .MIN_PER(2)) dut (
    .clk(clk), .rst(rst), .run(run), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .pu(pu), .cp(cp), .bl_en(bl_en), .p_bl_off(p_bl_off),
    .pulse(pulse), .blank(blank), .sync(sync), .trunc(trunc),
    .echo_cnt(echo_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  // Called on a falling edge; stores k=base..base+len-1 and returns at k=base+len.
  task automatic sample(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      pul[base+i] = pulse;
      blk[base+i] = blank;
      bsy[base+i] = busy;
      syn[base+i] = sync;
      trc[base+i] = trunc;
      ech[base+i] = echo_cnt;
      @(negedge clk);
    end
  endtask

  task automatic wait_sync(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sync === 1'b1) break;
    end
    chk({tag, "_sync_start"}, {31'd0, sync}, 32'd1);
  endtask

  task automatic restart(input string tag);
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    wait_sync(tag);
  endtask

  task automatic set_base();
    per = 32'd100; p1wid = 32'd3; del = 32'd5; p2wid = 32'd4;
    cp = 8'd2; pu = 1'b1; bl_en = 1'b1; p_bl_off = 16'd2;
  endtask

  initial begin
    int tr_cnt;
    rst = 1'b1; run = 1'b1;
    set_base();
    repeat (3) @(negedge clk);
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_blank", {31'd0, blank}, 32'd0);
    chk("rst_sync", {31'd0, sync}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_echo", {24'd0, echo_cnt}, 32'd0);
    rst = 1'b0; run = 1'b0;
    @(negedge clk);

    // Basic two-echo schedule
    restart("t1");
    sample(0, 101);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("t1_pulse_k%0d", k), {31'd0, pul[k]},
          {31'd0, in_rng(k, 0, 2) || in_rng(k, 8, 11) || in_rng(k, 22, 25)});
      chk($sformatf("t1_blank_k%0d", k), {31'd0, blk[k]},
          {31'd0, in_rng(k, 0, 4) || in_rng(k, 8, 13) || in_rng(k, 22, 27)});
      chk($sformatf("t1_busy_k%0d", k), {31'd0, bsy[k]}, {31'd0, in_rng(k, 0, 25)});
    end
    chk("t1_echo_k0", {24'd0, ech[0]}, 32'd0);
    chk("t1_echo_k7", {24'd0, ech[7]}, 32'd0);
    chk("t1_echo_k8", {24'd0, ech[8]}, 32'd1);
    chk("t1_echo_k21", {24'd0, ech[21]}, 32'd1);
    chk("t1_echo_k22", {24'd0, ech[22]}, 32'd2);
    chk("t1_echo_k60", {24'd0, ech[60]}, 32'd2);
    chk("t1_sync_k1", {31'd0, syn[1]}, 32'd0);
    chk("t1_sync_k99", {31'd0, syn[99]}, 32'd0);
    chk("t1_sync_k100", {31'd0, syn[100]}, 32'd1);
    chk("t1_echo_k100", {24'd0, ech[100]}, 32'd0);
    tr_cnt = 0;
    for (int k = 0; k <= 100; k++) tr_cnt += int'(trc[k]);
    chk("t1_trunc_count", tr_cnt, 32'd0);

    // Short period truncates the second echo
    per = 32'd20;
    restart("t2");
    sample(0, 60);
    for (int k = 0; k < 60; k++) begin
      chk($sformatf("t2_pulse_k%0d", k), {31'd0, pul[k]},
          {31'd0, in_rng(k % 20, 0, 2) || in_rng(k % 20, 8, 11)});
    end
    chk("t2_trunc_k0", {31'd0, trc[0]}, 32'd0);
    chk("t2_trunc_k19", {31'd0, trc[19]}, 32'd0);
    chk("t2_trunc_k20", {31'd0, trc[20]}, 32'd1);
    chk("t2_trunc_k21", {31'd0, trc[21]}, 32'd0);
    chk("t2_trunc_k40", {31'd0, trc[40]}, 32'd1);
    chk("t2_sync_k20", {31'd0, syn[20]}, 32'd1);
    chk("t2_sync_k40", {31'd0, syn[40]}, 32'd1);

    // No echoes, pulse 1 disabled
    set_base();
    cp = 8'd0; pu = 1'b0; per = 32'd50;
    restart("t3");
    sample(0, 50);
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("t3_pulse_k%0d", k), {31'd0, pul[k]}, 32'd0);
      chk($sformatf("t3_busy_k%0d", k), {31'd0, bsy[k]}, {31'd0, in_rng(k, 0, 2)});
      chk($sformatf("t3_echo_k%0d", k), {24'd0, ech[k]}, 32'd0);
    end

    // Zero delay: P1 and P2 contiguous
    set_base();
    del = 32'd0; cp = 8'd1;
    restart("t4");
    sample(0, 20);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_pulse_k%0d", k), {31'd0, pul[k]}, {31'd0, in_rng(k, 0, 6)});
    end
    chk("t4_echo_k2", {24'd0, ech[2]}, 32'd0);
    chk("t4_echo_k3", {24'd0, ech[3]}, 32'd1);

    // Mid-period parameter change waits for the next period start
    set_base();
    restart("t5");
    sample(0, 50);
    p1wid = 32'd10;
    sample(50, 150);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("t5_pulse_k%0d", k), {31'd0, pul[k]},
          {31'd0, in_rng(k, 0, 2) || in_rng(k, 8, 11) || in_rng(k, 22, 25)});
    end
    for (int k = 100; k < 125; k++) begin
      chk($sformatf("t5_pulse_k%0d", k), {31'd0, pul[k]},
          {31'd0, in_rng(k, 100, 109) || in_rng(k, 115, 118) || in_rng(k, 129, 132)});
    end

    // Reset inside a P2, run held high
    set_base();
    restart("t6");
    sample(0, 9);
    chk("t6_pulse_k9", {31'd0, pulse}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_pulse", {31'd0, pulse}, 32'd0);
    chk("t6_rst_blank", {31'd0, blank}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_echo", {24'd0, echo_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_sync_after_rst", {31'd0, sync}, 32'd1);
    chk("t6_pulse_after_rst", {31'd0, pulse}, 32'd1);

    // Dropping run mid-sequence idles without trunc
    sample(0, 9);
    run = 1'b0;
    @(negedge clk);
    chk("t7_pulse", {31'd0, pulse}, 32'd0);
    chk("t7_trunc", {31'd0, trunc}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_blank", {31'd0, blank}, 32'd0);
    @(negedge clk);
    chk("t7_trunc_later", {31'd0, trunc}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Consumes the pulse parameter registers driven by the UART command block and turns them into the real-time pulse train.
- Each period: pulse 1, then `cp` refocusing pulses in Hahn/CPMG spacing, plus a receiver-blanking gate and a scope sync.
- Parameters are shadowed at each period start, so serial updates never corrupt a sequence in flight.
- Sits between the command block and the output pins, in the 201 MHz domain.

Parameters:
- CNT_W, 32, width of the period/width/delay counters.
- MIN_PER, 2, smallest period honoured; `per` values below this are treated as MIN_PER.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  enable; 0 holds the block idle.
- per  in  32  period in cycles.
- p1wid  in  32  pulse-1 width in cycles.
- del  in  32  delay τ in cycles.
- p2wid  in  32  refocusing pulse width in cycles.
- pu  in  1  pulse-1 enable.
- cp  in  8  number of refocusing pulses (0 to 255).
- bl_en  in  1  blanking enable.
- p_bl_off  in  16  blank hold-off after each pulse falling edge, in cycles.
- pulse  out  1  RF gate.
- blank  out  1  receiver protection gate.
- sync  out  1  one-cycle strobe at period start.
- trunc  out  1  one-cycle strobe when a period ends before its sequence completes.
- echo_cnt  out  8  index of the current/last refocusing pulse.
- busy  out  1  sequence in progress (states P1..GAPN).

Behaviour:
- Reset: all outputs 0, state IDLE, period counter 0, shadow registers 0. Applies mid-pulse too: outputs are low on the cycle after rst is sampled.
- Timebase:
  - Cycle index k = 0 is the cycle in which sync=1.
  - All outputs are registered and aligned to k.
  - Period counter runs 0..P-1, then wraps; P = max(per, MIN_PER), sampled at k=0.
- Shadowing: at k=0, per, p1wid, del, p2wid, pu, cp, bl_en and p_bl_off are copied to shadow registers. Input changes at k≠0 take effect at the next k=0.
- run:
  - run=0: IDLE, outputs 0, counter cleared.
  - The first cycle with run=1 is k=0.
  - Dropping run mid-period returns to IDLE on the next cycle with outputs low; trunc is not asserted.
- States: IDLE, P1, GAP1, P2, GAPN, HOLD.
- Schedule (w1=p1wid, d=del, w2=p2wid, n=cp):
  - P1: k in [0, w1). pulse = pu. busy=1 even when pu=0.
  - GAP1: next d cycles.
  - P2 number j (0-based, j<n): starts at k = w1 + d + j·(w2 + 2d) and lasts w2 cycles.
  - GAPN: 2d cycles between consecutive P2s. The 2d arithmetic is 33 bits, with no overflow.
  - After the last P2, or after GAP1 when n=0: HOLD until wrap, busy=0. When n=0 the GAP1 cycles are not used; the block goes to HOLD immediately after P1.
- Zero-length phases:
  - Any width or delay of 0 makes that phase zero cycles long; it is skipped within the same cycle, so there are no bubble cycles.
  - d=0 makes P1 and P2 contiguous, with pulse held high.
- echo_cnt: 0 at k=0; set to j+1 on the first cycle of P2 number j; holds its value through HOLD.
- Wrap:
  - At the counter wrap the schedule restarts at k=0 regardless of state.
  - If the state was not HOLD, trunc=1 on that k=0 cycle.
  - pulse is low for at least that one cycle only if the new schedule says so; otherwise there is no forced gap.
- blank:
  - If shadow bl_en=0, blank=0.
  - Otherwise blank=1 whenever pulse=1, and for p_bl_off cycles after each pulse falling edge.
  - A new pulse during the hold-off retriggers it.
  - The hold-off counter is cleared at k=0.
- Simultaneous events:
  - rst overrides run.
  - Wrap overrides any phase transition in the same cycle.

Test Plan:
- per=100, p1wid=3, del=5, p2wid=4, cp=2, pu=1, bl_en=1, p_bl_off=2 → pulse high k=0–2, 8–11, 22–25; blank high k=0–4, 8–13, 22–27; sync at k=0 and k=100; echo_cnt 1 at k=8 and 2 at k=22; trunc never asserted.
- Same settings with per=20 → the second P2 never occurs; trunc=1 at k=0 of each following period; pulse high only at k=0–2 and 8–11 in each period.
- cp=0, pu=0, per=50 → pulse never high; busy high k=0–2 only; echo_cnt stays 0.
- del=0, p1wid=3, p2wid=4, cp=1 → pulse high contiguously k=0–6.
- Change p1wid from 3 to 10 at k=50 with per=100 → the current period is unchanged; pulse is high k=0–9 in the next period.
- Assert rst at k=9 (inside a P2), then hold run=1 → pulse, blank and busy are 0 on the following cycle; sync fires on the first cycle after rst is released.
